// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words and writes them to consecutive word addresses starting at 0.
module imem_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] word_count,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] count_q, count_d;
    logic [9:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    // Lower three bytes of the word being received; the fourth byte goes
    // straight into wd so wd only changes when a word is written.
    logic [23:0] asm_q, asm_d;
    logic [31:0] wa_q, wa_d;
    logic [31:0] wd_q, wd_d;
    logic        err_q, err_d;

    logic        count_legal;
    logic        last_word;

    assign count_legal = (word_count != 11'd0) && (word_count <= 11'd1024);
    assign last_word   = ({1'b0, word_idx_q} == (count_q - 11'd1));

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            wa_q       <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (count_legal) begin
                        count_d    = word_count;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        err_d      = 1'b0;
                        state_d    = RECV;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (abort) begin
                    // Partial word is dropped; byte position restarts at 0.
                    byte_idx_d = '0;
                    state_d    = IDLE;
                end else if (byte_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    unique case (byte_idx_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        2'd3: begin
                            wa_d    = {20'b0, word_idx_q, 2'b00};
                            wd_d    = {byte_data, asm_q};
                            state_d = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + 10'd1;
                    state_d    = RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_ready = (state_q == RECV);
    assign we         = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign wa         = wa_q;
    assign wd         = wd_q;
    assign err        = err_q;

endmodule
